// File: rtl/cgra_net_pkg.sv
// rtl/cgra_net_pkg.sv - shared types for the CGRA neighbour write link
package cgra_net_pkg;

  localparam int unsigned WIDTH      = 16;
  localparam int unsigned NUM_INPUTS = 4;

  // Element i of a vector is vec[i]; shared with the receiver-side code.
  typedef logic [NUM_INPUTS-1:0][WIDTH-1:0] vec_t;

  typedef enum logic [1:0] {
    TX_IDLE    = 2'd0,
    TX_REQ     = 2'd1,
    TX_RELEASE = 2'd2
  } tx_state_t;

endpackage

// File: rtl/vec_fifo.sv
// rtl/vec_fifo.sv - circular buffer of result vectors awaiting transmission
module vec_fifo
  import cgra_net_pkg::*;
#(
  parameter int unsigned width      = 16,
  parameter int unsigned num_inputs = 4,
  parameter int unsigned fifo_depth = 4,
  localparam int unsigned PW = $clog2(fifo_depth),
  localparam int unsigned CW = PW + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             push_i,
  input  logic [num_inputs-1:0][width-1:0] data_i,
  input  logic                             pop_i,
  output logic [num_inputs-1:0][width-1:0] head_o,
  output logic [CW-1:0]                    count_o,
  output logic                             full_o,
  output logic                             empty_o
);

  logic [num_inputs-1:0][width-1:0] mem_q [fifo_depth];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(fifo_depth));
  assign empty_o = (count_q == '0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

  always_comb begin
    wr_ptr_d = do_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = do_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    count_d  = count_q + CW'(do_push) - CW'(do_pop);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries covered by count_q are ever read out.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

endmodule

// File: rtl/vec_net_tx.sv
// rtl/vec_net_tx.sv - buffers vector fu results and writes them to a neighbour tile
module vec_net_tx
  import cgra_net_pkg::*;
#(
  parameter int unsigned width       = 16,
  parameter int unsigned num_inputs  = 4,
  parameter int unsigned fifo_depth  = 4,
  parameter int unsigned ack_timeout = 255,
  localparam int unsigned CW = $clog2(fifo_depth) + 1
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_vld,
  output logic                             in_rdy,
  input  logic [num_inputs-1:0][width-1:0] in_data,
  output logic                             write_en,
  input  logic                             write_rdy,
  output logic [num_inputs-1:0][width-1:0] w_data_out,
  input  logic                             write_ack,
  output logic [CW-1:0]                    fifo_count,
  output logic                             busy,
  output logic                             err
);

  localparam int unsigned TW = (ack_timeout > 0) ? $clog2(ack_timeout + 1) : 1;

  tx_state_t                        state_q, state_d;
  logic                             we_q, we_d;
  logic [num_inputs-1:0][width-1:0] wdata_q, wdata_d;
  logic [TW-1:0]                    tcnt_q, tcnt_d;
  logic                             err_q, err_d;
  logic                             pop;
  logic [num_inputs-1:0][width-1:0] head;
  logic                             full, empty;

  vec_fifo #(
    .width      (width),
    .num_inputs (num_inputs),
    .fifo_depth (fifo_depth)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (in_vld),
    .data_i  (in_data),
    .pop_i   (pop),
    .head_o  (head),
    .count_o (fifo_count),
    .full_o  (full),
    .empty_o (empty)
  );

  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    wdata_d = wdata_q;
    tcnt_d  = '0;
    err_d   = err_q;
    pop     = 1'b0;
    unique case (state_q)
      TX_IDLE: begin
        if (!empty && write_rdy) begin
          wdata_d = head;
          we_d    = 1'b1;
          state_d = TX_REQ;
        end
      end
      TX_REQ: begin
        // The head is popped only once the neighbour has committed it.
        if (write_ack) begin
          we_d    = 1'b0;
          pop     = 1'b1;
          state_d = TX_RELEASE;
        end else begin
          tcnt_d = (tcnt_q == '1) ? tcnt_q : tcnt_q + TW'(1);
          if ((ack_timeout != 0) && (tcnt_d == TW'(ack_timeout))) err_d = 1'b1;
        end
      end
      TX_RELEASE: begin
        if (!write_ack) state_d = TX_IDLE;
      end
      default: begin
        state_d = TX_IDLE;
        we_d    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= TX_IDLE;
      we_q    <= 1'b0;
      wdata_q <= '0;
      tcnt_q  <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      wdata_q <= wdata_d;
      tcnt_q  <= tcnt_d;
      err_q   <= err_d;
    end
  end

  assign in_rdy     = !full;
  assign write_en   = we_q;
  assign w_data_out = wdata_q;
  assign busy       = !empty || (state_q != TX_IDLE);
  assign err        = err_q;

endmodule
